// File: rtl/periph_bus_pkg.sv
// Shared types and helpers for the peripheral bus controller.
//   state_e            controller FSM states
//   ERR_RDATA_DEFAULT  read data returned with every error response
//   idx_width()        slot-index width for a given slot count (at least 1 bit)
package periph_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational slot decoder for the peripheral window.
//   addr  in   byte address of the request
//   hit   out  address falls inside one of the NUM_SLAVES populated slots
//   idx   out  slot index, addr[SLOT_AW +: IDX_W]
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter logic [31:0] PERIPH_BASE = 32'h0200_0000,
  parameter int unsigned SLOT_AW     = 12,
  parameter int unsigned IDX_W       = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned TopLsb = SLOT_AW + IDX_W;

  logic base_match;
  // Offset bits inside a slot play no part in decoding.
  logic unused_offset;

  assign unused_offset = ^addr[SLOT_AW-1:0];
  assign idx           = addr[SLOT_AW +: IDX_W];
  assign base_match    = (addr[31:TopLsb] == PERIPH_BASE[31:TopLsb]);
  // Index space may be larger than the populated slot count.
  assign hit           = base_match && (32'(idx) < NUM_SLAVES);

endmodule

// File: rtl/periph_bus_ctrl.sv
// Peripheral port controller: decodes periph_mem_* requests to one of NUM_SLAVES slots,
// runs the slot handshake and returns a one-cycle response. Unmapped addresses and slots
// that stay silent for TIMEOUT_CYCLES get an error response, so the bus never hangs.
//   sys_clk, rst_n                 clock, asynchronous active-low reset
//   periph_mem_valid/ready         request (held until ready) / one-cycle response strobe
//   periph_mem_addr/wdata/wstrb    request address, write data, byte enables (0 = read)
//   periph_mem_rdata               response data, held after the strobe
//   s_sel/s_addr/s_wdata/s_wstrb   one-hot slot select and registered request fields
//   s_ready/s_rdata                per-slot completion strobe and read data
//   err_flag/err_addr/err_clr      sticky error flag, last error address, flag clear
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] PERIPH_BASE    = 32'h0200_0000,
  parameter int unsigned SLOT_AW        = 12,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     periph_mem_valid,
  output logic                     periph_mem_ready,
  input  logic [31:0]              periph_mem_addr,
  input  logic [31:0]              periph_mem_wdata,
  input  logic [3:0]               periph_mem_wstrb,
  output logic [31:0]              periph_mem_rdata,
  output logic [NUM_SLAVES-1:0]    s_sel,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic                     err_flag,
  output logic [31:0]              err_addr,
  input  logic                     err_clr
);

  localparam int unsigned IdxW   = idx_width(NUM_SLAVES);
  localparam int unsigned CntW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     addr_q;

  logic            dec_hit;
  logic [IdxW-1:0] dec_idx;
  logic            sel_ready;
  logic [31:0]     sel_rdata;

  periph_addr_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .PERIPH_BASE (PERIPH_BASE),
    .SLOT_AW     (SLOT_AW),
    .IDX_W       (IdxW)
  ) u_decode (
    .addr (periph_mem_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Only the latched slot is ever listened to; strobes from other slots are ignored.
  assign sel_ready = s_ready[idx_q];
  assign sel_rdata = s_rdata[32*idx_q +: 32];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      idx_q            <= '0;
      cnt_q            <= '0;
      addr_q           <= '0;
      periph_mem_ready <= 1'b0;
      periph_mem_rdata <= '0;
      s_sel            <= '0;
      s_addr           <= '0;
      s_wdata          <= '0;
      s_wstrb          <= '0;
      err_flag         <= 1'b0;
      err_addr         <= '0;
    end else begin
      // Ready is raised on the edge into StResp, so it is high exactly while in StResp.
      periph_mem_ready <= 1'b0;
      // Later error-set assignments in this block override the clear.
      if (err_clr) begin
        err_flag <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (periph_mem_valid) begin
            if (dec_hit) begin
              idx_q   <= dec_idx;
              addr_q  <= periph_mem_addr;
              s_addr  <= {{(32-SLOT_AW){1'b0}}, periph_mem_addr[SLOT_AW-1:0]};
              s_wdata <= periph_mem_wdata;
              s_wstrb <= periph_mem_wstrb;
              s_sel   <= NUM_SLAVES'(1) << dec_idx;
              cnt_q   <= '0;
              state_q <= StAccess;
            end else begin
              periph_mem_rdata <= ERR_RDATA;
              periph_mem_ready <= 1'b1;
              err_flag         <= 1'b1;
              err_addr         <= periph_mem_addr;
              state_q          <= StResp;
            end
          end
        end

        StAccess: begin
          if (!periph_mem_valid) begin
            // Master withdrew the request: release the slot silently.
            s_sel   <= '0;
            state_q <= StIdle;
          end else if (sel_ready) begin
            // Completion beats a timeout landing in the same cycle.
            periph_mem_rdata <= (s_wstrb == 4'h0) ? sel_rdata : 32'h0;
            periph_mem_ready <= 1'b1;
            s_sel            <= '0;
            state_q          <= StResp;
          end else if (cnt_q == CntLast) begin
            periph_mem_rdata <= ERR_RDATA;
            periph_mem_ready <= 1'b1;
            err_flag         <= 1'b1;
            err_addr         <= addr_q;
            s_sel            <= '0;
            state_q          <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StResp: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Bench for periph_bus_ctrl: directed and randomized requests, a slave model with
// programmable latency and stray strobes, and a scoreboard-driven response monitor.
module tb_periph_bus_ctrl;

  localparam int unsigned NS   = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int unsigned TO   = 64;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic               sys_clk;
  logic               rst_n;
  logic               periph_mem_valid;
  logic               periph_mem_ready;
  logic [31:0]        periph_mem_addr;
  logic [31:0]        periph_mem_wdata;
  logic [3:0]         periph_mem_wstrb;
  logic [31:0]        periph_mem_rdata;
  logic [NS-1:0]      s_sel;
  logic [31:0]        s_addr;
  logic [31:0]        s_wdata;
  logic [3:0]         s_wstrb;
  logic [NS-1:0]      s_ready;
  logic [32*NS-1:0]   s_rdata;
  logic               err_flag;
  logic [31:0]        err_addr;
  logic               err_clr;

  periph_bus_ctrl #(
    .NUM_SLAVES     (NS),
    .PERIPH_BASE    (BASE),
    .SLOT_AW        (12),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (ERRD)
  ) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .periph_mem_valid (periph_mem_valid),
    .periph_mem_ready (periph_mem_ready),
    .periph_mem_addr  (periph_mem_addr),
    .periph_mem_wdata (periph_mem_wdata),
    .periph_mem_wstrb (periph_mem_wstrb),
    .periph_mem_rdata (periph_mem_rdata),
    .s_sel            (s_sel),
    .s_addr           (s_addr),
    .s_wdata          (s_wdata),
    .s_wstrb          (s_wstrb),
    .s_ready          (s_ready),
    .s_rdata          (s_rdata),
    .err_flag         (err_flag),
    .err_addr         (err_addr),
    .err_clr          (err_clr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        eflag;
    logic [31:0] eaddr;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          issue_cyc = 0;

  // Slave-side expectations for the transaction in flight.
  logic [31:0] slot_data [NS];
  logic [NS-1:0] exp_sel_vec = '0;
  logic [31:0] exp_off = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  int          cur_lat = 0;
  int          exp_dur = 0;

  // Reference model of the sticky error state.
  logic        m_eflag = 1'b0;
  logic [31:0] m_eaddr = '0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  always_comb begin
    s_rdata = '0;
    for (int i = 0; i < int'(NS); i++) s_rdata[32*i +: 32] = slot_data[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: strobes the selected slot after cur_lat cycles (0 = never), injects
  // random strobes on every other slot, and checks the select/request fields.
  initial begin
    int sel_cnt;
    logic [NS-1:0] prev_sel;
    logic [NS-1:0] nxt;
    sel_cnt = 0;
    prev_sel = '0;
    s_ready = '0;
    forever begin
      @(negedge sys_clk);
      if (s_sel != '0) begin
        sel_cnt = sel_cnt + 1;
        if (sel_cnt == 1) begin
          chk("s_sel_onehot", 64'(s_sel), 64'(exp_sel_vec));
          chk("s_sel_delay", 64'(cyc - issue_cyc), 64'(1));
          chk("s_addr", 64'(s_addr), 64'(exp_off));
          chk("s_wdata", 64'(s_wdata), 64'(exp_wdata));
          chk("s_wstrb", 64'(s_wstrb), 64'(exp_wstrb));
        end else begin
          chk("s_sel_stable", 64'(s_sel), 64'(prev_sel));
        end
        prev_sel = s_sel;
      end else begin
        if (sel_cnt != 0 && exp_dur != 0) chk("s_sel_duration", 64'(sel_cnt), 64'(exp_dur));
        sel_cnt = 0;
      end
      nxt = NS'($urandom) & ~exp_sel_vec;
      if (s_sel != '0 && cur_lat != 0 && sel_cnt == cur_lat) nxt = nxt | exp_sel_vec;
      s_ready = nxt;
    end
  end

  // Response monitor: every ready strobe must match the oldest scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (rst_n && periph_mem_ready) begin
        if (sb.size() == 0) begin
          n_chk = n_chk + 1;
          n_fail = n_fail + 1;
          $display("FAIL unexpected_ready: got ready with rdata %0h, required no response",
                   periph_mem_rdata);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", 64'(periph_mem_rdata), 64'(e.rdata));
          chk("resp_latency", 64'(cyc - e.issue), 64'(e.lat));
          chk("resp_err_flag", 64'(err_flag), 64'(e.eflag));
          chk("resp_err_addr", 64'(err_addr), 64'(e.eaddr));
        end
      end
    end
  end

  // Computes the expected outcome from the address map and slave latency, sets the slave
  // expectations and puts the request on the bus. Call at posedge+1.
  task automatic setup_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int lat, input logic [31:0] dsel,
                           output exp_t e);
    bit hit;
    int slot;
    hit  = (addr >= BASE) && (addr < BASE + NS * 4096);
    slot = hit ? int'((addr - BASE) / 4096) : 0;
    for (int i = 0; i < int'(NS); i++) slot_data[i] = $urandom;
    if (hit) slot_data[slot] = dsel;
    exp_sel_vec = hit ? (NS'(1) << slot) : '0;
    exp_off     = addr & 32'h0000_0FFF;
    exp_wdata   = wdata;
    exp_wstrb   = wstrb;
    cur_lat     = lat;
    e.issue     = cyc;
    if (!hit) begin
      e.rdata = ERRD; e.err = 1'b1; e.lat = 1; exp_dur = 0;
    end else if (lat >= 1 && lat <= int'(TO)) begin
      e.rdata = (wstrb == 4'h0) ? dsel : 32'h0; e.err = 1'b0; e.lat = lat + 1; exp_dur = lat;
    end else begin
      e.rdata = ERRD; e.err = 1'b1; e.lat = TO + 1; exp_dur = TO;
    end
    issue_cyc        = cyc;
    periph_mem_addr  = addr;
    periph_mem_wdata = wdata;
    periph_mem_wstrb = wstrb;
    periph_mem_valid = 1'b1;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int lat, input logic [31:0] dsel);
    exp_t e;
    bit got;
    setup_req(addr, wdata, wstrb, lat, dsel, e);
    if (e.err) begin
      m_eflag = 1'b1;
      m_eaddr = addr;
    end
    e.eflag = m_eflag;
    e.eaddr = m_eaddr;
    sb.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge sys_clk);
      got = periph_mem_ready;
    end
    chk("ready_seen", 64'(got), 64'(1));
    @(posedge sys_clk);
    #1;
    periph_mem_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge sys_clk);
    #1;
    err_clr = 1'b0;
    m_eflag = 1'b0;
    chk("err_clr", 64'(err_flag), 64'(m_eflag));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(periph_mem_ready), 64'(0));
    chk({tag, "_rdata"}, 64'(periph_mem_rdata), 64'(0));
    chk({tag, "_s_sel"}, 64'(s_sel), 64'(0));
    chk({tag, "_s_addr"}, 64'(s_addr), 64'(0));
    chk({tag, "_s_wdata"}, 64'(s_wdata), 64'(0));
    chk({tag, "_s_wstrb"}, 64'(s_wstrb), 64'(0));
    chk({tag, "_err_flag"}, 64'(err_flag), 64'(0));
    chk({tag, "_err_addr"}, 64'(err_addr), 64'(0));
  endtask

  initial begin
    exp_t e;
    logic [31:0] a;
    logic [3:0]  ws;
    int          r;
    int          lat;

    for (int i = 0; i < int'(NS); i++) slot_data[i] = '0;
    rst_n = 1'b1;
    periph_mem_valid = 1'b0;
    periph_mem_addr = '0;
    periph_mem_wdata = '0;
    periph_mem_wstrb = '0;
    err_clr = 1'b0;
    #2 rst_n = 1'b0;
    #10 chk_all_zero("reset");
    #11 rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Read hit on slot 1, strobe in the first access cycle.
    do_req(32'h0200_1004, 32'h0, 4'h0, 1, 32'h1234_5678);
    // Write hit on slot 3.
    do_req(32'h0200_3010, 32'hCAFE_F00D, 4'hF, 2, 32'h5555_AAAA);
    // Unmapped address, then clear the sticky flag.
    do_req(32'h0300_0000, 32'h0, 4'h0, 1, 32'h0);
    pulse_clr();
    // Silent slot times out; strobe on the last counter cycle still completes normally.
    do_req(32'h0200_2000, 32'h0, 4'h0, 0, 32'h0BAD_0BAD);
    do_req(32'h0200_2000, 32'h0, 4'h0, int'(TO), 32'h600D_600D);

    // Abort after three access cycles: select drops, no response, no error.
    setup_req(32'h0200_0008, 32'h0, 4'h0, 0, 32'h0, e);
    exp_dur = 4;
    repeat (4) @(posedge sys_clk);
    #1 periph_mem_valid = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    chk("abort_s_sel", 64'(s_sel), 64'(0));
    chk("abort_err_flag", 64'(err_flag), 64'(m_eflag));

    // Reset in the middle of an access.
    setup_req(32'h0200_1100, 32'h1111_2222, 4'h3, 0, 32'h0, e);
    exp_dur = 0;
    repeat (5) @(posedge sys_clk);
    #3 rst_n = 1'b0;
    periph_mem_valid = 1'b0;
    #1 chk_all_zero("midreset");
    m_eflag = 1'b0;
    m_eaddr = '0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    do_req(32'h0200_2abc, 32'h0, 4'h0, 2, 32'hFACE_0001);

    // Back-to-back hits on slots 0 and 3 with stray strobes on the other slots.
    do_req(32'h0200_0010, 32'h0, 4'h0, 3, 32'hA0A0_0000);
    do_req(32'h0200_3020, 32'h0, 4'h0, 1, 32'hB3B3_3333);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) a = $urandom;
      else a = BASE + $urandom_range(0, NS - 1) * 4096 + $urandom_range(0, 4095);
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      r = int'($urandom_range(0, 99));
      lat = (r < 8) ? 0 : (r < 13) ? int'(TO) : int'($urandom_range(1, 5));
      do_req(a, $urandom, ws, lat, $urandom);
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end

    repeat (5) @(posedge sys_clk);
    #1 chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
